wb_write_queue: RTL and testbench



---
 rtl/wb_write_queue.sv | 137 +++++++++++++
 tb/tb_wb_write_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback queue in front of the register file: buffers results, retires one per cycle
// in acceptance order, and offers two bypass ports that see the youngest queued value.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_reg,
    input  logic [31:0]   in_data,

    input  logic          hold,
    output logic          regWrite,
    output logic [4:0]    writeReg,
    output logic [31:0]   writeData,

    input  logic [4:0]    lookup_reg1,
    output logic          lookup_hit1,
    output logic [31:0]   lookup_data1,
    input  logic [4:0]    lookup_reg2,
    output logic          lookup_hit2,
    output logic [31:0]   lookup_data2,

    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [4:0]    mem_reg_q  [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          accept;
    logic          store;
    logic          pop;

    // ------------------------------------------------------------------
    // Status and handshake
    // ------------------------------------------------------------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign in_ready = !full;

    // Register zero is architecturally constant, so such results complete
    // the handshake but never occupy a slot.
    assign accept   = in_valid && in_ready;
    assign store    = accept && (in_reg != 5'd0);

    // Drain depends only on queue state and hold, never on the incoming beat.
    assign pop      = !empty && !hold;

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    assign regWrite  = pop;
    assign writeReg  = empty ? 5'd0  : mem_reg_q[head_q];
    assign writeData = empty ? 32'd0 : mem_data_q[head_q];

    // ------------------------------------------------------------------
    // Pointer and occupancy next-state
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (store) begin
            tail_d = tail_q + AW'(1);
        end

        unique case ({store, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_reg_q[tail_q]  <= in_reg;
            mem_data_q[tail_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Bypass lookup
    // ------------------------------------------------------------------
    // Walk occupied slots oldest to youngest from head; the last match wins,
    // which yields the most recently accepted value for that register.
    always_comb begin
        lookup_hit1  = 1'b0;
        lookup_data1 = 32'd0;
        lookup_hit2  = 1'b0;
        lookup_data2 = 32'd0;

        for (int k = 0; k < DEPTH; k++) begin : scan
            logic [AW-1:0] idx;
            idx = head_q + AW'(k);
            if ((AW+1)'(k) < count_q) begin
                if ((lookup_reg1 != 5'd0) && (mem_reg_q[idx] == lookup_reg1)) begin
                    lookup_hit1  = 1'b1;
                    lookup_data1 = mem_data_q[idx];
                end
                if ((lookup_reg2 != 5'd0) && (mem_reg_q[idx] == lookup_reg2)) begin
                    lookup_hit2  = 1'b1;
                    lookup_data2 = mem_data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: a scoreboard of accepted writes is matched
// against every register-file write, plus directed checks on status, latency and bypass.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_reg;
    logic [31:0]   in_data;
    logic          hold;
    logic          regWrite;
    logic [4:0]    writeReg;
    logic [31:0]   writeData;
    logic [4:0]    lookup_reg1;
    logic          lookup_hit1;
    logic [31:0]   lookup_data1;
    logic [4:0]    lookup_reg2;
    logic          lookup_hit2;
    logic [31:0]   lookup_data2;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_writes = 0;
    wr_t sb[$];

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_reg       (in_reg),
        .in_data      (in_data),
        .hold         (hold),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .lookup_reg1  (lookup_reg1),
        .lookup_hit1  (lookup_hit1),
        .lookup_data1 (lookup_data1),
        .lookup_reg2  (lookup_reg2),
        .lookup_hit2  (lookup_hit2),
        .lookup_data2 (lookup_data2),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one beat starting just after a rising edge; returns whether it was accepted.
    task automatic push(input logic [4:0] r, input logic [31:0] d, output logic acc);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc && (r != 5'd0)) sb.push_back('{r: r, d: d});
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (!empty && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", empty, 1'b1);
        check("sb_drained", sb.size(), 0);
    endtask

    // Write monitor: every register-file write must match the oldest accepted entry.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count_le_depth", count <= (AW+1)'(DEPTH), 1'b1);
            if (hold) check("hold_blocks_write", regWrite, 1'b0);
            if (regWrite) begin
                n_writes++;
                if (sb.size() == 0) begin
                    check("unexpected_write", {writeReg, writeData}, 37'd0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_reg", writeReg, e.r);
                    check("wr_data", writeData, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   w0;
        logic [4:0] exp_regs [4];

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_reg      = 5'd0;
        in_data     = 32'd0;
        hold        = 1'b0;
        lookup_reg1 = 5'd0;
        lookup_reg2 = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_regWrite", regWrite, 1'b0);
        check("rst_writeReg", writeReg, 0);
        check("rst_writeData", writeData, 0);
        lookup_reg1 = 5'd1;
        lookup_reg2 = 5'd2;
        #1;
        check("rst_hit1", lookup_hit1, 1'b0);
        check("rst_data1", lookup_data1, 0);
        check("rst_hit2", lookup_hit2, 1'b0);
        check("rst_data2", lookup_data2, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset mid-stream with three queued entries
        hold = 1'b1;
        push(5'd1, 32'h0000_0101, acc);
        push(5'd2, 32'h0000_0202, acc);
        push(5'd3, 32'h0000_0303, acc);
        check("t1_count3", count, 3);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("t1_count", count, 0);
        check("t1_empty", empty, 1'b1);
        check("t1_regWrite", regWrite, 1'b0);
        check("t1_in_ready", in_ready, 1'b1);
        hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w0 = n_writes;
        repeat (4) @(posedge clk);
        #1;
        check("t1_no_write_after_release", n_writes - w0, 0);
        check("t1_still_empty", empty, 1'b1);

        // Test 2: back-to-back pushes drain on the following edges
        push(5'd5, 32'h1111_1111, acc);
        check("t2_rw_first", regWrite, 1'b1);
        check("t2_reg_first", writeReg, 5'd5);
        check("t2_data_first", writeData, 32'h1111_1111);
        push(5'd6, 32'h2222_2222, acc);
        check("t2_rw_second", regWrite, 1'b1);
        check("t2_reg_second", writeReg, 5'd6);
        check("t2_data_second", writeData, 32'h2222_2222);
        @(posedge clk);
        #1;
        check("t2_empty", empty, 1'b1);
        check("t2_rw_idle", regWrite, 1'b0);

        // Test 3: fill under hold, refuse a fifth beat, then drain in order
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_regs[i] = 5'(10 + i);
            push(exp_regs[i], 32'hC000_0000 + i, acc);
            check("t3_accept", acc, 1'b1);
        end
        check("t3_full", full, 1'b1);
        check("t3_in_ready", in_ready, 1'b0);
        check("t3_count", count, DEPTH);
        push(5'd20, 32'hBAD0_BAD0, acc);
        check("t3_fifth_refused", acc, 1'b0);
        check("t3_count_after_refuse", count, DEPTH);
        hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("t3_rw", regWrite, 1'b1);
            check("t3_order", writeReg, exp_regs[i]);
            @(posedge clk);
        end
        #1;
        check("t3_empty", empty, 1'b1);
        check("t3_sb", sb.size(), 0);

        // Test 4: bypass returns the youngest match
        hold = 1'b1;
        push(5'd7, 32'h0000_000A, acc);
        push(5'd7, 32'h0000_000B, acc);
        lookup_reg1 = 5'd7;
        lookup_reg2 = 5'd9;
        #1;
        check("t4_hit1", lookup_hit1, 1'b1);
        check("t4_data1", lookup_data1, 32'h0000_000B);
        check("t4_hit2", lookup_hit2, 1'b0);
        check("t4_data2", lookup_data2, 0);
        push(5'd9, 32'h0000_0099, acc);
        #1;
        check("t4_hit2_late", lookup_hit2, 1'b1);
        check("t4_data2_late", lookup_data2, 32'h0000_0099);
        hold = 1'b0;
        wait_empty(20);

        // Test 5: register zero is accepted and dropped
        w0 = n_writes;
        push(5'd0, 32'h0000_DEAD, acc);
        check("t5_accept", acc, 1'b1);
        check("t5_count", count, 0);
        check("t5_empty", empty, 1'b1);
        check("t5_rw", regWrite, 1'b0);
        lookup_reg1 = 5'd0;
        #1;
        check("t5_hit_r0", lookup_hit1, 1'b0);
        check("t5_data_r0", lookup_data1, 0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_write", n_writes - w0, 0);

        // Test 6: steady push/pop at count two, pointers wrap
        hold = 1'b1;
        push(5'd21, 32'hA5A5_0000, acc);
        push(5'd22, 32'hA5A5_0001, acc);
        check("t6_count_start", count, 2);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(5'(1 + ($urandom % 31)), $urandom, acc);
            check("t6_accept", acc, 1'b1);
            check("t6_count_steady", count, 2);
        end
        wait_empty(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
